// File: rtl/mult_pkg.sv
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the shift-add multiplier.
//                Holds the controller state encodings, the default operand
//                width, and a helper that sizes the step counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    // Default operand width; also the number of add steps.
    localparam int MULT_N = 4;

    // Controller state encodings (3 bits each).
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_ADD  = 3'd3;
    localparam logic [2:0] ST_SHB  = 3'd4;
    localparam logic [2:0] ST_SHP  = 3'd5;
    localparam logic [2:0] ST_FIN  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CLR  = ST_CLR,
        S_LOAD = ST_LOAD,
        S_ADD  = ST_ADD,
        S_SHB  = ST_SHB,
        S_SHP  = ST_SHP,
        S_FIN  = ST_FIN
    } state_e;

    // Step counter width: $clog2(n), but never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_step_counter.sv
// ============================================================================
//  Module      : mult_step_counter
//  Description : Add-step counter for the multiplier controller. Counts
//                0..N-1 and saturates at N-1; flags the final step.
//  Ports       : clk      - rising-edge clock
//                clr      - synchronous active-high reset (count -> 0)
//                load0_i  - restart the count at 0
//                inc_i    - advance to the next step
//                last_o   - count equals N-1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_step_counter
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic clk,
    input  logic clr,
    input  logic load0_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int               CW       = cnt_width(N);
    localparam logic [CW-1:0]    LAST_VAL = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load0_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST_VAL)) begin
            // Holding at N-1 keeps the count from wrapping inside a sequence.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST_VAL);

endmodule

`default_nettype wire

// File: rtl/mult_ctrl.sv
// ============================================================================
//  Module      : mult_ctrl
//  Description : Sequencer for the 4-bit shift-add multiplier datapath.
//                Issues dclr, ld, then N add steps separated by shift pairs
//                (shb, shp), then a one-cycle done pulse. All outputs are a
//                Moore decode of the state register.
//  Ports       : clk     - rising-edge clock
//                clr     - synchronous active-high reset
//                start_i - request one multiplication (honoured in IDLE only)
//                b0_i    - LSB of datapath B register (used when ADD_GATE=1)
//                dclr_o  - datapath clear strobe
//                ld_o    - operand load strobe
//                ldp_o   - product load/accumulate strobe
//                shb_o   - B register shift strobe
//                shp_o   - product register shift strobe
//                busy_o  - sequence in progress (CLR..SHP)
//                done_o  - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_ctrl
    import mult_pkg::*;
#(
    parameter int N        = MULT_N,
    parameter int ADD_GATE = 0
) (
    input  logic clk,
    input  logic clr,
    input  logic start_i,
    input  logic b0_i,
    output logic dclr_o,
    output logic ld_o,
    output logic ldp_o,
    output logic shb_o,
    output logic shp_o,
    output logic busy_o,
    output logic done_o
);

    state_e state_q;
    state_e state_d;

    logic   w_last;
    logic   w_load0;
    logic   w_inc;
    logic   w_add_en;

    // With gating off the constant term forces every ADD to strobe ldp;
    // with gating on only a set B LSB does.
    assign w_add_en = (ADD_GATE == 0) | b0_i;

    mult_step_counter #(
        .N (N)
    ) u_step_counter (
        .clk     (clk),
        .clr     (clr),
        .load0_i (w_load0),
        .inc_i   (w_inc),
        .last_o  (w_last)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dclr_o  = 1'b0;
        ld_o    = 1'b0;
        ldp_o   = 1'b0;
        shb_o   = 1'b0;
        shp_o   = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        w_load0 = 1'b0;
        w_inc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                dclr_o  = 1'b1;
                busy_o  = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                ld_o    = 1'b1;
                busy_o  = 1'b1;
                w_load0 = 1'b1;
                state_d = S_ADD;
            end
            S_ADD: begin
                // The step advances regardless of whether ldp fires, so the
                // cycle count never depends on operand values.
                ldp_o   = w_add_en;
                busy_o  = 1'b1;
                state_d = w_last ? S_FIN : S_SHB;
            end
            S_SHB: begin
                shb_o   = 1'b1;
                busy_o  = 1'b1;
                state_d = S_SHP;
            end
            S_SHP: begin
                shp_o   = 1'b1;
                busy_o  = 1'b1;
                w_inc   = 1'b1;
                state_d = S_ADD;
            end
            S_FIN: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
